// File: rtl/config_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_bitstream_loader
// Purpose  : Takes a configuration bitstream as parallel words on a
//            valid/ready stream and shifts it, MSB first, into the serial
//            config chain of a logic tile. Exactly CHAIN_LENGTH shift
//            strobes are issued per load; unused low bits of the final
//            word are dropped.
// Options  : `define CONFIG_LOADER_CRC_EN to add a CRC-16-CCITT check of the
//            emitted bits against the low 16 bits of one trailing word.
// Ports    : clock          rising-edge clock shared with the chain
//            nreset         asynchronous active-low reset
//            start          pulse to begin a load (IDLE/DONE only)
//            word_data      bitstream word, MSB first
//            word_valid     word_data valid
//            word_ready     loader accepts a word this cycle
//            config_data    serial bit to chain data_in (registered)
//            config_enable  shift strobe to chain enable (registered)
//            busy           load in progress
//            done           load complete, held until start or reset
//            error          CRC mismatch (0 when CRC option is off)
// Revision : 1.0 - initial release
// ============================================================================
module config_bitstream_loader #(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = 146,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_data,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int                    c_WBIT_W     = $clog2(WORD_WIDTH + 1);
    localparam logic [COUNT_WIDTH-1:0] c_CHAIN_LAST = COUNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [c_WBIT_W-1:0]    c_WORD_LAST  = c_WBIT_W'(WORD_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WORD = 3'd1,
        S_SHIFT     = 3'd2,
        S_CHECK     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                  r_state,       w_state_next;
    logic [WORD_WIDTH-1:0]   r_shift,       w_shift_next;
    logic [COUNT_WIDTH-1:0]  r_bit_cnt,     w_bit_cnt_next;
    logic [c_WBIT_W-1:0]     r_word_bits,   w_word_bits_next;
    logic                    r_config_data, w_config_data_next;
    logic                    r_config_en,   w_config_en_next;
    logic                    r_done,        w_done_next;
    logic                    w_emit;
    logic                    w_emit_bit;

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0]             r_crc,         w_crc_next;
    logic                    r_error,       w_error_next;
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_shift_next       = r_shift;
        w_bit_cnt_next     = r_bit_cnt;
        w_word_bits_next   = r_word_bits;
        w_config_data_next = 1'b0;
        w_config_en_next   = 1'b0;
        w_done_next        = r_done;
        w_emit             = 1'b0;
        w_emit_bit         = r_shift[WORD_WIDTH-1];
`ifdef CONFIG_LOADER_CRC_EN
        w_crc_next         = r_crc;
        w_error_next       = r_error;
`endif

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next   = S_WAIT_WORD;
                    w_bit_cnt_next = '0;
                    w_done_next    = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
                    w_crc_next     = 16'hFFFF;
                    w_error_next   = 1'b0;
`endif
                end
            end
            S_WAIT_WORD: begin
                // The MSB goes straight to the output register on the
                // accept edge so the first strobe follows immediately.
                if (word_valid) begin
                    w_state_next     = S_SHIFT;
                    w_emit           = 1'b1;
                    w_emit_bit       = word_data[WORD_WIDTH-1];
                    w_shift_next     = word_data << 1;
                    w_word_bits_next = c_WBIT_W'(1);
                end
            end
            S_SHIFT: begin
                // r_bit_cnt / r_word_bits count bits already on the output,
                // including the one being presented this cycle.
                if ((r_word_bits != c_WORD_LAST) && (r_bit_cnt != c_CHAIN_LAST)) begin
                    w_emit           = 1'b1;
                    w_shift_next     = r_shift << 1;
                    w_word_bits_next = r_word_bits + c_WBIT_W'(1);
                end else if (r_bit_cnt != c_CHAIN_LAST) begin
                    w_state_next = S_WAIT_WORD;
                end else begin
`ifdef CONFIG_LOADER_CRC_EN
                    w_state_next = S_CHECK;
`else
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
`endif
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            S_CHECK: begin
                if (word_valid) begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                    w_error_next = (word_data[15:0] != r_crc);
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_emit) begin
            w_config_en_next   = 1'b1;
            w_config_data_next = w_emit_bit;
            w_bit_cnt_next     = r_bit_cnt + COUNT_WIDTH'(1);
`ifdef CONFIG_LOADER_CRC_EN
            w_crc_next = {r_crc[14:0], 1'b0} ^
                         ((r_crc[15] ^ w_emit_bit) ? 16'h1021 : 16'h0000);
`endif
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_word_bits   <= '0;
            r_config_data <= 1'b0;
            r_config_en   <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_shift       <= w_shift_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_word_bits   <= w_word_bits_next;
            r_config_data <= w_config_data_next;
            r_config_en   <= w_config_en_next;
            r_done        <= w_done_next;
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_crc   <= 16'hFFFF;
            r_error <= 1'b0;
        end else begin
            r_crc   <= w_crc_next;
            r_error <= w_error_next;
        end
    end
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign word_ready    = (r_state == S_WAIT_WORD) || (r_state == S_CHECK);
    assign busy          = (r_state == S_WAIT_WORD) || (r_state == S_SHIFT) ||
                           (r_state == S_CHECK);
    assign config_data   = r_config_data;
    assign config_enable = r_config_en;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_config_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_bitstream_loader
// Purpose  : Self-checking bench for config_bitstream_loader with random
//            bitstream words. A model chain is shifted from the DUT strobes
//            and compared with the image expected from the words sent.
//            Honours CONFIG_LOADER_CRC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_bitstream_loader;

    localparam int c_WW      = 32;
    localparam int c_CL      = 146;
    localparam int c_NW      = (c_CL + c_WW - 1) / c_WW;
    localparam int c_TIMEOUT = 400;

    logic            clock = 1'b0;
    logic            nreset = 1'b0;
    logic            start = 1'b0;
    logic [c_WW-1:0] word_data = '0;
    logic            word_valid = 1'b0;
    logic            word_ready;
    logic            config_data;
    logic            config_enable;
    logic            busy;
    logic            done;
    logic            error;

    config_bitstream_loader #(
        .WORD_WIDTH   (c_WW),
        .CHAIN_LENGTH (c_CL),
        .COUNT_WIDTH  (8)
    ) dut (
        .clock         (clock),
        .nreset        (nreset),
        .start         (start),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .config_data   (config_data),
        .config_enable (config_enable),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Chain model and strobe monitor, sampled mid-cycle
    // ------------------------------------------------------------------
    int              cyc = 0;
    int              pulses = 0;
    int              last_pulse_cyc = 0;
    int              done_rise_cyc = 0;
    int              overlap = 0;
    logic            done_q = 1'b0;
    logic [c_CL-1:0] chain = '0;

    always @(negedge clock) begin
        cyc    <= cyc + 1;
        done_q <= done;
        if (config_enable) begin
            pulses         <= pulses + 1;
            last_pulse_cyc <= cyc;
            chain          <= {chain[c_CL-2:0], config_data};
        end
        if (done && !done_q) done_rise_cyc <= cyc;
        if (config_enable && word_ready) overlap <= overlap + 1;
    end

    // ------------------------------------------------------------------
    // Reference: image and CRC computed straight from the word list
    // ------------------------------------------------------------------
    logic [c_WW-1:0] words [c_NW];

    function automatic logic [c_CL-1:0] image_of();
        logic [c_CL-1:0] img;
        img = '0;
        for (int i = 0; i < c_CL; i++)
            img[c_CL-1-i] = words[i / c_WW][c_WW-1 - (i % c_WW)];
        return img;
    endfunction

    function automatic logic [15:0] crc_of(input logic [c_CL-1:0] img);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = c_CL - 1; i >= 0; i--) begin
            fb = c[15] ^ img[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // All stimulus changes happen on the falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Present a word and hold it until the loader has taken it.
    task automatic send_word(input logic [c_WW-1:0] w, output bit ok);
        int  c;
        bit  was_ready;
        c = 0;
        ok = 1'b0;
        word_data  = w;
        word_valid = 1'b1;
        do begin
            was_ready = word_ready;
            @(negedge clock);
            c++;
        end while (!was_ready && c < c_TIMEOUT);
        word_valid = 1'b0;
        ok = was_ready;
    endtask

    task automatic run_load(input int gap_word, input int gap_len, input bit start_mid,
                            input bit crc_flip, input bit fresh, input string tag);
        int              p0, gp, c, seen;
        bit              ok;
        logic [c_CL-1:0] exp_img;
        logic [15:0]     crc_word;
        if (fresh)
            for (int i = 0; i < c_NW; i++) words[i] = $urandom;
        exp_img = image_of();
        p0 = pulses;

        pulse_start();
        check({tag, "_start_state"}, {done, busy, word_ready, error}, 4'b0110);

        for (int i = 0; i < c_NW; i++) begin
            if (i == gap_word) begin
                c = 0;
                while (!word_ready && c < c_TIMEOUT) begin
                    @(negedge clock);
                    c++;
                end
                gp = pulses;
                repeat (gap_len) @(negedge clock);
                check({tag, "_gap_pulses"}, pulses - gp, 0);
            end
            send_word(words[i], ok);
            check({tag, "_accept"}, ok, 1'b1);
            if (start_mid && i == 1) begin
                pulse_start();
                check({tag, "_busy_after_mid_start"}, {busy, done}, 2'b10);
            end
        end

`ifdef CONFIG_LOADER_CRC_EN
        crc_word = crc_of(exp_img);
        if (crc_flip) crc_word = crc_word ^ (16'h1 << $urandom_range(15, 0));
        send_word({16'($urandom), crc_word}, ok);
        check({tag, "_crc_accept"}, ok, 1'b1);
`else
        crc_word = 16'h0;
`endif

        c = 0;
        while (!done && c < c_TIMEOUT) begin
            @(negedge clock);
            c++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        repeat (2) @(negedge clock);
        #1;
        check({tag, "_pulse_count"}, pulses - p0, c_CL);
        check({tag, "_image"}, chain, exp_img);
`ifndef CONFIG_LOADER_CRC_EN
        check({tag, "_done_latency"}, done_rise_cyc - last_pulse_cyc, 1);
`endif
        check({tag, "_end_state"}, {done, busy, word_ready, config_enable, error},
              {4'b1000, crc_flip});

        // The loader must not take further words once the load is over.
        seen = 0;
        word_valid = 1'b1;
        word_data  = $urandom;
        repeat (4) begin
            if (word_ready) seen++;
            @(negedge clock);
        end
        word_valid = 1'b0;
        check({tag, "_no_extra_word"}, {seen, pulses - p0}, {32'd0, c_CL});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [c_CL-1:0] img1;
    int              p;
    bit              ok;

    initial begin
        nreset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {word_ready, config_data, config_enable, busy, done, error}, 6'b0);
        nreset = 1'b1;
        p = pulses;
        repeat (5) @(negedge clock);
        check("idle_quiet", {pulses - p, 26'(0), busy, word_ready}, 0);

        run_load(-1, 0, 1'b0, 1'b0, 1'b1, "s1_b2b");
        img1 = chain;
        run_load(2, 10, 1'b0, 1'b0, 1'b0, "s2_gap");
        check("s2_same_image", chain, img1);
        run_load(-1, 0, 1'b1, 1'b0, 1'b1, "s3_start_mid");

        // Reset partway through word 2.
        for (int i = 0; i < c_NW; i++) words[i] = $urandom;
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(words[i], ok);
        repeat (7) @(negedge clock);
        #2 nreset = 1'b0;
        #1;
        check("s4_reset_outputs", {word_ready, config_data, config_enable, busy, done, error}, 6'b0);
        @(negedge clock);
        nreset = 1'b1;
        p = pulses;
        word_valid = 1'b1;
        repeat (20) @(negedge clock);
        check("s4_quiet_after_reset", {pulses - p, 29'(0), busy, word_ready, done}, 0);
        word_valid = 1'b0;
        run_load(-1, 0, 1'b0, 1'b0, 1'b1, "s4_reload");

`ifdef CONFIG_LOADER_CRC_EN
        run_load(-1, 0, 1'b0, 1'b1, 1'b1, "s6_crc_bad");
        run_load(-1, 0, 1'b0, 1'b0, 1'b1, "s6_crc_good");
`endif

        for (int k = 0; k < 3; k++)
            run_load($urandom_range(c_NW - 1, 0), $urandom_range(12, 1),
                     1'($urandom_range(1, 0)), 1'b0, 1'b1, "rand");

        check("strobe_ready_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
